// File: rtl/aurora_tx_frame_arbiter_pkg.sv
// Shared types and default widths for the Aurora TX frame arbiter.
package aurora_tx_frame_arbiter_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int STRB_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;
endpackage

// File: rtl/aurora_rr_pick2.sv
// Two-requester round-robin selector: a lone requester wins, a tie goes
// to the requester that was not served last.
module aurora_rr_pick2 (
  input  logic [1:0] req,
  input  logic       lp,
  output logic       sel
);
  // Combinational pick; sel is a don't-care when nothing requests.
  always_comb begin
    sel = 1'b0;
    case (req)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~lp;
      default: sel = 1'b0;
    endcase
  end
endmodule

// File: rtl/aurora_tx_frame_arbiter.sv
// Frame-boundary round-robin arbiter sharing the Aurora TX AXI4-Stream
// port between two sources; flushes the owning frame on channel loss.
module aurora_tx_frame_arbiter
  import aurora_tx_frame_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int STRB_WIDTH = STRB_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  USER_CLK,
  input  logic                  RESET,
  input  logic                  CHANNEL_UP,
  input  logic [0:DATA_WIDTH-1] S0_TDATA,
  input  logic [STRB_WIDTH-1:0] S0_TKEEP,
  input  logic                  S0_TLAST,
  input  logic                  S0_TVALID,
  output logic                  S0_TREADY,
  input  logic [0:DATA_WIDTH-1] S1_TDATA,
  input  logic [STRB_WIDTH-1:0] S1_TKEEP,
  input  logic                  S1_TLAST,
  input  logic                  S1_TVALID,
  output logic                  S1_TREADY,
  output logic [0:DATA_WIDTH-1] M_TDATA,
  output logic [STRB_WIDTH-1:0] M_TKEEP,
  output logic                  M_TLAST,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [1:0]            GRANT,
  output logic [CNT_WIDTH-1:0]  FRAMES_SENT0,
  output logic [CNT_WIDTH-1:0]  FRAMES_SENT1,
  output logic [CNT_WIDTH-1:0]  FRAMES_DROP0,
  output logic [CNT_WIDTH-1:0]  FRAMES_DROP1
);
  arb_state_t state, state_nxt;
  logic g, g_nxt, lp, lp_nxt;
  logic pick, sel_valid, sel_last, rdy;
  logic inc_sent, inc_drop;
  logic [1:0][CNT_WIDTH-1:0] sent, drop;

  // g only changes in IDLE, so these views are stable for a whole frame.
  assign sel_valid = g ? S1_TVALID : S0_TVALID;
  assign sel_last  = g ? S1_TLAST  : S0_TLAST;

  aurora_rr_pick2 u_pick (
    .req ({S1_TVALID, S0_TVALID}),
    .lp  (lp),
    .sel (pick)
  );

  // State, grant index and last-served pointer.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      g     <= 1'b0;
      lp    <= 1'b1;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      lp    <= lp_nxt;
    end
  end

  // Next-state: grant in IDLE, finish or abort in BUSY, drain in FLUSH.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    lp_nxt    = lp;
    inc_sent  = 1'b0;
    inc_drop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CHANNEL_UP && (S0_TVALID || S1_TVALID)) begin
          g_nxt     = pick;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Channel loss wins: the ready gating below blocks any beat this cycle.
        if (!CHANNEL_UP) begin
          inc_drop  = 1'b1;
          state_nxt = ST_FLUSH;
        end else if (sel_valid && M_TREADY && sel_last) begin
          inc_sent  = 1'b1;
          lp_nxt    = g;
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (sel_valid && sel_last) begin
          lp_nxt    = g;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: zero-latency pass-through in BUSY, sink-only in FLUSH.
  always_comb begin
    M_TDATA  = '0;
    M_TKEEP  = '0;
    M_TLAST  = 1'b0;
    M_TVALID = 1'b0;
    rdy      = 1'b0;
    GRANT    = 2'b00;
    case (state)
      ST_BUSY: begin
        M_TDATA  = g ? S1_TDATA : S0_TDATA;
        M_TKEEP  = g ? S1_TKEEP : S0_TKEEP;
        M_TLAST  = sel_last;
        M_TVALID = sel_valid & CHANNEL_UP;
        rdy      = M_TREADY & CHANNEL_UP;
        GRANT    = g ? 2'b10 : 2'b01;
      end
      ST_FLUSH: begin
        rdy   = 1'b1;
        GRANT = g ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
    S0_TREADY = rdy & ~g;
    S1_TREADY = rdy & g;
  end

  // Per-source frame counters, wrapping.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      sent <= '0;
      drop <= '0;
    end else begin
      if (inc_sent) sent[g] <= sent[g] + CNT_WIDTH'(1);
      if (inc_drop) drop[g] <= drop[g] + CNT_WIDTH'(1);
    end
  end

  assign FRAMES_SENT0 = sent[0];
  assign FRAMES_SENT1 = sent[1];
  assign FRAMES_DROP0 = drop[0];
  assign FRAMES_DROP1 = drop[1];
endmodule

// File: tb/tb_aurora_tx_frame_arbiter.sv
// Bench for aurora_tx_frame_arbiter: directed vector table, hand-written
// fairness / reset / wrap sequences, then random traffic vs a frame model.
// Counters are built 8 bits wide here so the wrap boundary is reachable.
module tb_aurora_tx_frame_arbiter;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 8;

  logic          USER_CLK = 1'b0;
  logic          RESET, CHANNEL_UP, M_TREADY;
  logic [0:DW-1] S0_TDATA, S1_TDATA, M_TDATA;
  logic [SW-1:0] S0_TKEEP, S1_TKEEP, M_TKEEP;
  logic          S0_TLAST, S1_TLAST, M_TLAST;
  logic          S0_TVALID, S1_TVALID, M_TVALID;
  logic          S0_TREADY, S1_TREADY;
  logic [1:0]    GRANT;
  logic [CW-1:0] FRAMES_SENT0, FRAMES_SENT1, FRAMES_DROP0, FRAMES_DROP1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 USER_CLK = ~USER_CLK;

  aurora_tx_frame_arbiter #(.DATA_WIDTH(DW), .STRB_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .USER_CLK(USER_CLK), .RESET(RESET), .CHANNEL_UP(CHANNEL_UP),
    .S0_TDATA(S0_TDATA), .S0_TKEEP(S0_TKEEP), .S0_TLAST(S0_TLAST),
    .S0_TVALID(S0_TVALID), .S0_TREADY(S0_TREADY),
    .S1_TDATA(S1_TDATA), .S1_TKEEP(S1_TKEEP), .S1_TLAST(S1_TLAST),
    .S1_TVALID(S1_TVALID), .S1_TREADY(S1_TREADY),
    .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .GRANT(GRANT),
    .FRAMES_SENT0(FRAMES_SENT0), .FRAMES_SENT1(FRAMES_SENT1),
    .FRAMES_DROP0(FRAMES_DROP0), .FRAMES_DROP1(FRAMES_DROP1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int s0, input int s1, input int d0, input int d1);
    chk({nm, "_sent0"}, 64'(FRAMES_SENT0), 64'(s0));
    chk({nm, "_sent1"}, 64'(FRAMES_SENT1), 64'(s1));
    chk({nm, "_drop0"}, 64'(FRAMES_DROP0), 64'(d0));
    chk({nm, "_drop1"}, 64'(FRAMES_DROP1), 64'(d1));
  endtask

  // ---------------- frame-level reference model ----------------
  // owner: -1 when nobody holds the port; discarding: owner's frame is being dropped.
  int owner, last_served;
  bit discarding;
  int m_sent[2], m_drop[2];

  task automatic model_reset();
    owner = -1; discarding = 0; last_served = 1;
    m_sent = '{0, 0}; m_drop = '{0, 0};
  endtask

  task automatic model_check(input int cyc);
    logic [31:0] d[2];
    logic [SW-1:0] k[2];
    bit v[2], l[2];
    bit ev, el;
    bit [1:0] er, eg;
    logic [31:0] ed;
    logic [SW-1:0] ek;
    d = '{S0_TDATA, S1_TDATA}; k = '{S0_TKEEP, S1_TKEEP};
    v = '{S0_TVALID, S1_TVALID}; l = '{S0_TLAST, S1_TLAST};
    ev = 0; el = 0; er = 2'b00; eg = 2'b00; ed = '0; ek = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      if (!discarding) begin
        ed = d[owner]; ek = k[owner]; el = l[owner];
        ev = v[owner] && CHANNEL_UP;
        er[owner] = M_TREADY && CHANNEL_UP;
      end else begin
        er[owner] = 1'b1;
      end
    end
    chk($sformatf("rnd%0d_ctl", cyc), 64'({M_TVALID, M_TLAST, S1_TREADY, S0_TREADY, GRANT}),
        64'({ev, el, er, eg}));
    chk($sformatf("rnd%0d_data", cyc), 64'({M_TDATA, M_TKEEP}), 64'({ed, ek}));
    chk_cnt($sformatf("rnd%0d", cyc), m_sent[0], m_sent[1], m_drop[0], m_drop[1]);
  endtask

  task automatic model_step();
    bit v[2], l[2];
    v = '{S0_TVALID, S1_TVALID}; l = '{S0_TLAST, S1_TLAST};
    if (RESET) begin
      model_reset();
    end else if (owner < 0) begin
      if (CHANNEL_UP && (v[0] || v[1]))
        owner = (v[0] && v[1]) ? 1 - last_served : (v[0] ? 0 : 1);
    end else if (!discarding) begin
      if (!CHANNEL_UP) begin
        discarding = 1;
        m_drop[owner] = (m_drop[owner] + 1) % (1 << CW);
      end else if (v[owner] && M_TREADY && l[owner]) begin
        m_sent[owner] = (m_sent[owner] + 1) % (1 << CW);
        last_served = owner; owner = -1;
      end
    end else if (v[owner] && l[owner]) begin
      last_served = owner; owner = -1; discarding = 0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit up; bit v0; logic [31:0] d0; bit l0; bit v1; logic [31:0] d1; bit l1; bit rdy;
    bit ev; logic [31:0] ed; bit el; bit er0; bit er1; logic [1:0] eg;
  } vec_t;

  function automatic vec_t mk(bit up, bit v0, logic [31:0] d0, bit l0, bit v1, logic [31:0] d1,
                              bit l1, bit rdy, bit ev, logic [31:0] ed, bit el, bit er0,
                              bit er1, logic [1:0] eg);
    vec_t r;
    r.up = up; r.v0 = v0; r.d0 = d0; r.l0 = l0; r.v1 = v1; r.d1 = d1; r.l1 = l1; r.rdy = rdy;
    r.ev = ev; r.ed = ed; r.el = el; r.er0 = er0; r.er1 = er1; r.eg = eg;
    return r;
  endfunction

  task automatic zero_inputs();
    CHANNEL_UP = 0; M_TREADY = 0;
    S0_TVALID = 0; S0_TLAST = 0; S0_TDATA = '0; S0_TKEEP = '0;
    S1_TVALID = 0; S1_TLAST = 0; S1_TDATA = '0; S1_TKEEP = '0;
  endtask

  task automatic apply_reset(input string nm);
    RESET = 1; zero_inputs();
    repeat (2) @(posedge USER_CLK);
    @(negedge USER_CLK);
    chk({nm, "_ctl"}, 64'({M_TVALID, M_TLAST, S1_TREADY, S0_TREADY, GRANT}), 64'h0);
    chk({nm, "_data"}, 64'({M_TDATA, M_TKEEP}), 64'h0);
    chk_cnt(nm, 0, 0, 0, 0);
    @(posedge USER_CLK); #1;
    RESET = 0;
    model_reset();
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] got[$];
    logic [31:0] tmp;
    int f[2], b[2];
    int frames;
    bit acc0, acc1;

    // up v0 d0 l0 v1 d1 l1 rdy | ev ed el er0 er1 grant
    tbl.push_back(mk(1,1,32'hA0000001,0,0,0,0,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(1,1,32'hA0000001,0,0,0,0,1, 1,32'hA0000001,0,1,0,2'b01));
    tbl.push_back(mk(1,1,32'hA0000002,0,0,0,0,1, 1,32'hA0000002,0,1,0,2'b01));
    tbl.push_back(mk(1,1,32'hA0000003,0,0,0,0,1, 1,32'hA0000003,0,1,0,2'b01));
    tbl.push_back(mk(1,1,32'hA0000004,1,0,0,0,1, 1,32'hA0000004,1,1,0,2'b01));
    tbl.push_back(mk(1,0,0,0,1,32'hB0000001,0,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(1,0,0,0,1,32'hB0000001,0,1, 1,32'hB0000001,0,0,1,2'b10));
    tbl.push_back(mk(1,0,0,0,1,32'hB0000002,0,0, 1,32'hB0000002,0,0,0,2'b10));
    tbl.push_back(mk(1,0,0,0,1,32'hB0000002,0,1, 1,32'hB0000002,0,0,1,2'b10));
    tbl.push_back(mk(1,1,32'hA0000005,0,1,32'hB0000003,0,0, 1,32'hB0000003,0,0,0,2'b10));
    tbl.push_back(mk(1,1,32'hA0000005,0,1,32'hB0000003,0,1, 1,32'hB0000003,0,0,1,2'b10));
    tbl.push_back(mk(1,1,32'hA0000005,0,1,32'hB0000004,0,1, 1,32'hB0000004,0,0,1,2'b10));
    tbl.push_back(mk(1,1,32'hA0000005,0,1,32'hB0000005,1,1, 1,32'hB0000005,1,0,1,2'b10));
    tbl.push_back(mk(1,1,32'hC0000001,0,1,32'hB0000006,0,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(1,1,32'hC0000001,0,1,32'hB0000006,0,1, 1,32'hC0000001,0,1,0,2'b01));
    tbl.push_back(mk(1,1,32'hC0000002,0,1,32'hB0000006,0,1, 1,32'hC0000002,0,1,0,2'b01));
    tbl.push_back(mk(0,1,32'hC0000003,0,1,32'hB0000006,0,1, 0,32'hC0000003,0,0,0,2'b01));
    tbl.push_back(mk(0,1,32'hC0000003,0,1,32'hB0000006,0,1, 0,0,0,1,0,2'b01));
    tbl.push_back(mk(0,1,32'hC0000004,0,1,32'hB0000006,0,1, 0,0,0,1,0,2'b01));
    tbl.push_back(mk(0,1,32'hC0000005,0,1,32'hB0000006,0,1, 0,0,0,1,0,2'b01));
    tbl.push_back(mk(0,1,32'hC0000006,1,1,32'hB0000006,0,1, 0,0,0,1,0,2'b01));
    tbl.push_back(mk(0,0,0,0,1,32'hB0000006,1,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(0,0,0,0,1,32'hB0000006,1,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(1,0,0,0,1,32'hB0000006,1,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(1,0,0,0,1,32'hB0000006,1,1, 1,32'hB0000006,1,0,1,2'b10));
    tbl.push_back(mk(1,1,32'hD0000001,1,1,32'hB0000007,1,1, 0,0,0,0,0,2'b00));
    tbl.push_back(mk(1,1,32'hD0000001,1,1,32'hB0000007,1,1, 1,32'hD0000001,1,1,0,2'b01));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,0,0,0,0,2'b00));

    apply_reset("reset0");
    S0_TKEEP = 4'hF; S1_TKEEP = 4'h3;
    foreach (tbl[i]) begin
      CHANNEL_UP = tbl[i].up; M_TREADY = tbl[i].rdy;
      S0_TVALID = tbl[i].v0; S0_TDATA = tbl[i].d0; S0_TLAST = tbl[i].l0;
      S1_TVALID = tbl[i].v1; S1_TDATA = tbl[i].d1; S1_TLAST = tbl[i].l1;
      @(negedge USER_CLK);
      chk($sformatf("vec%0d_ctl", i), 64'({M_TVALID, M_TLAST, S0_TREADY, S1_TREADY, GRANT}),
          64'({tbl[i].ev, tbl[i].el, tbl[i].er0, tbl[i].er1, tbl[i].eg}));
      chk($sformatf("vec%0d_data", i), 64'(M_TDATA), 64'(tbl[i].ed));
      @(posedge USER_CLK); #1;
    end
    chk_cnt("vec_end", 2, 2, 1, 0);

    // Reset on beat 2 of an S0 frame, with nonzero counters beforehand.
    CHANNEL_UP = 1; M_TREADY = 1;
    S0_TVALID = 1; S0_TLAST = 0; S0_TDATA = 32'hE0000001;
    @(posedge USER_CLK); #1;
    @(posedge USER_CLK); #1;
    S0_TDATA = 32'hE0000002; RESET = 1;
    @(negedge USER_CLK);
    chk("rstmid_beat2_valid", 64'(M_TVALID), 64'h1);
    @(posedge USER_CLK); #1;
    RESET = 0;
    @(negedge USER_CLK);
    chk("rstmid_ctl", 64'({M_TVALID, GRANT}), 64'h0);
    chk_cnt("rstmid", 0, 0, 0, 0);
    S0_TVALID = 0;
    @(posedge USER_CLK); #1;

    // Tie and fairness: both sources stream 3-beat frames.
    apply_reset("reset1");
    CHANNEL_UP = 1; M_TREADY = 1; S0_TKEEP = 4'hF; S1_TKEEP = 4'hF;
    S0_TVALID = 1; S1_TVALID = 1;
    f = '{0, 0}; b = '{0, 0}; frames = 0;
    for (int cyc = 0; cyc < 100 && frames < 4; cyc++) begin
      tmp = 32'h10000000 + 32'(f[0] * 16 + b[0]); S0_TDATA = tmp; S0_TLAST = (b[0] == 2);
      tmp = 32'h20000000 + 32'(f[1] * 16 + b[1]); S1_TDATA = tmp; S1_TLAST = (b[1] == 2);
      @(negedge USER_CLK);
      if (M_TVALID && M_TREADY) begin
        got.push_back(M_TDATA);
        if (M_TLAST) frames++;
      end
      acc0 = S0_TVALID && S0_TREADY;
      acc1 = S1_TVALID && S1_TREADY;
      @(posedge USER_CLK); #1;
      if (acc0) begin if (b[0] == 2) begin b[0] = 0; f[0]++; end else b[0]++; end
      if (acc1) begin if (b[1] == 2) begin b[1] = 0; f[1]++; end else b[1]++; end
    end
    S0_TVALID = 0; S1_TVALID = 0;
    chk("fair_beats", 64'(got.size()), 64'd12);
    for (int k = 0; k < 12 && k < got.size(); k++) begin
      tmp = (((k / 3) % 2) ? 32'h20000000 : 32'h10000000) + 32'(((k / 3) / 2) * 16 + k % 3);
      chk($sformatf("fair_beat%0d", k), 64'(got[k]), 64'(tmp));
    end
    chk_cnt("fair", 2, 2, 0, 0);

    // Counter wrap: 2^CW single-beat S1 frames, two cycles each.
    apply_reset("reset2");
    CHANNEL_UP = 1; M_TREADY = 1; S1_TVALID = 1; S1_TLAST = 1; S1_TDATA = 32'h5A5A5A5A;
    repeat (2 * ((1 << CW) - 1)) @(posedge USER_CLK);
    #1;
    chk_cnt("wrap_pre", 0, (1 << CW) - 1, 0, 0);
    repeat (2) @(posedge USER_CLK);
    #1;
    chk_cnt("wrap_post", 0, 0, 0, 0);
    S1_TVALID = 0;

    // Random traffic against the frame-level model.
    apply_reset("reset3");
    for (int i = 0; i < 4000; i++) begin
      RESET      = ($urandom_range(499) == 0);
      CHANNEL_UP = ($urandom_range(15) != 0);
      M_TREADY   = ($urandom_range(3) != 0);
      S0_TVALID  = ($urandom_range(3) != 0);
      S1_TVALID  = ($urandom_range(3) != 0);
      S0_TLAST   = ($urandom_range(3) == 0);
      S1_TLAST   = ($urandom_range(3) == 0);
      S0_TDATA   = $urandom; S1_TDATA = $urandom;
      S0_TKEEP   = SW'($urandom); S1_TKEEP = SW'($urandom);
      @(negedge USER_CLK);
      model_check(i);
      @(posedge USER_CLK);
      model_step();
      #1;
    end
    RESET = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
